// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF majority-vote wrapper.
// PUF_STABILITY_MASK_EN (optional) enables the per-bit instability mask in its users.
package puf_pkg;

    localparam int unsigned CHALL_W_DEF = 8;
    localparam int unsigned RESP_W_DEF  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh,
        StSample,
        StDone
    } state_t;

    // Strict majority of n samples; n is odd so there is never a tie.
    function automatic logic maj_bit(input int unsigned ones, input int unsigned n);
        return (2 * ones) > n;
    endfunction

endpackage

// File: rtl/puf_bit_vote_ctr.sv
// Per-bit ones counter for the response voter, with majority and disagreement outputs.
// PUF_STABILITY_MASK_EN defined: the unstable output is present.
module puf_bit_vote_ctr
    import puf_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample_en,
    input  logic sample_bit,
    output logic vote
`ifdef PUF_STABILITY_MASK_EN
    ,
    output logic unstable
`endif
);

    localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

    logic [CW-1:0] ones;

    // Width covers 0..NUM_SAMPLES, so no saturation is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones <= '0;
        end else if (clear) begin
            ones <= '0;
        end else if (sample_en && sample_bit) begin
            ones <= ones + CW'(1);
        end
    end

    assign vote = maj_bit(32'(ones), NUM_SAMPLES);

`ifdef PUF_STABILITY_MASK_EN
    assign unstable = (ones != '0) && (ones != CW'(NUM_SAMPLES));
`endif

endmodule

// File: rtl/puf_response_voter.sv
// Runs the PUF NUM_SAMPLES times per challenge and returns the per-bit majority response.
// PUF_STABILITY_MASK_EN defined: adds out_unstable (bit set where samples disagreed).
module puf_response_voter
    import puf_pkg::*;
#(
    parameter int unsigned CHALL_W     = CHALL_W_DEF,
    parameter int unsigned RESP_W      = RESP_W_DEF,
    parameter int unsigned NUM_SAMPLES = 5,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CHALL_W-1:0] req_chall,
    output logic               puf_en,
    output logic               puf_rst,
    output logic [CHALL_W-1:0] puf_chall,
    input  logic [RESP_W-1:0]  puf_response,
    input  logic               puf_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHALL_W-1:0] out_chall,
    output logic [RESP_W-1:0]  out_resp,
`ifdef PUF_STABILITY_MASK_EN
    output logic [RESP_W-1:0]  out_unstable,
`endif
    output logic               out_timeout
);

    localparam int unsigned SCW = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TLast = TW'(TIMEOUT - 1);
    localparam logic [SCW-1:0] SLast = SCW'(NUM_SAMPLES - 1);

    if ((NUM_SAMPLES % 2) == 0) begin : gen_bad_samples
        $error("puf_response_voter: NUM_SAMPLES must be odd and >= 1");
    end
    if (TIMEOUT < 1) begin : gen_bad_timeout
        $error("puf_response_voter: TIMEOUT must be >= 1");
    end

    state_t             state;
    logic [SCW-1:0]     sample_cnt;
    logic [TW-1:0]      wait_cnt;
    logic [CHALL_W-1:0] chall;
    logic               timed_out;
    logic               accept;
    logic               sample_en;
    logic [RESP_W-1:0]  vote_bits;

    assign accept    = req_valid && req_ready;
    assign sample_en = (state == StSample);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            req_ready  <= 1'b1;
            puf_en     <= 1'b0;
            puf_rst    <= 1'b0;
            out_valid  <= 1'b0;
            timed_out  <= 1'b0;
            chall      <= '0;
            sample_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        chall      <= req_chall;
                        sample_cnt <= '0;
                        timed_out  <= 1'b0;
                        req_ready  <= 1'b0;
                        puf_en     <= 1'b1;
                        puf_rst    <= 1'b1;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    puf_rst  <= 1'b0;
                    wait_cnt <= '0;
                    state    <= StWaitLow;
                end
                // Ready must drop first so a response left over from the last run is skipped.
                StWaitLow: begin
                    if (!puf_ready) begin
                        wait_cnt <= '0;
                        state    <= StWaitHigh;
                    end else if (wait_cnt == TLast) begin
                        puf_en    <= 1'b0;
                        out_valid <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                StWaitHigh: begin
                    if (puf_ready) begin
                        state <= StSample;
                    end else if (wait_cnt == TLast) begin
                        puf_en    <= 1'b0;
                        out_valid <= 1'b1;
                        timed_out <= 1'b1;
                        state     <= StDone;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                StSample: begin
                    sample_cnt <= sample_cnt + SCW'(1);
                    if (sample_cnt == SLast) begin
                        puf_en    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        puf_rst <= 1'b1;
                        state   <= StStart;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef PUF_STABILITY_MASK_EN
    logic [RESP_W-1:0] unstable_bits;
`endif

    for (genvar i = 0; i < RESP_W; i++) begin : gen_bit
`ifdef PUF_STABILITY_MASK_EN
        puf_bit_vote_ctr #(
            .NUM_SAMPLES(NUM_SAMPLES)
        ) u_ctr (
            .clk       (clk),
            .rst       (rst),
            .clear     (accept),
            .sample_en (sample_en),
            .sample_bit(puf_response[i]),
            .vote      (vote_bits[i]),
            .unstable  (unstable_bits[i])
        );
`else
        puf_bit_vote_ctr #(
            .NUM_SAMPLES(NUM_SAMPLES)
        ) u_ctr (
            .clk       (clk),
            .rst       (rst),
            .clear     (accept),
            .sample_en (sample_en),
            .sample_bit(puf_response[i])
            ,
            .vote      (vote_bits[i])
        );
`endif
    end

    assign puf_chall   = chall;
    assign out_chall   = chall;
    assign out_timeout = timed_out;
    // An aborted evaluation reports zero response and flags every bit as untrustworthy.
    assign out_resp    = timed_out ? '0 : vote_bits;
`ifdef PUF_STABILITY_MASK_EN
    assign out_unstable = timed_out ? '1 : unstable_bits;
`endif

endmodule

// File: tb/tb_puf_response_voter.sv
// Self-checking bench for puf_response_voter with a behavioural PUF stub and a result scoreboard.
module tb_puf_response_voter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_chall;
    logic       puf_en;
    logic       puf_rst;
    logic [7:0] puf_chall;
    logic [7:0] puf_response;
    logic       puf_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_chall;
    logic [7:0] out_resp;
    logic       out_timeout;
`ifdef PUF_STABILITY_MASK_EN
    logic [7:0] out_unstable;
`endif

    always #5 clk = ~clk;

    puf_response_voter #(
        .CHALL_W    (8),
        .RESP_W     (8),
        .NUM_SAMPLES(5),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_chall   (req_chall),
        .puf_en      (puf_en),
        .puf_rst     (puf_rst),
        .puf_chall   (puf_chall),
        .puf_response(puf_response),
        .puf_ready   (puf_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chall   (out_chall),
        .out_resp    (out_resp),
`ifdef PUF_STABILITY_MASK_EN
        .out_unstable(out_unstable),
`endif
        .out_timeout (out_timeout)
    );

    typedef struct packed {
        logic [7:0] chall;
        logic [7:0] resp;
        logic [7:0] unst;
        logic       tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // PUF stub. Modes: 0 normal, 1 ready held high (stale data) after restart, 2 ready stuck low,
    // 3 like 0 but responses come from tab[].
    int         mode       = 0;
    int         stub_cnt   = 100;
    int         rst_pulses = 0;
    int         tab_base   = 0;
    logic [7:0] stub_resp  = 8'h00;
    logic [7:0] tab[5];
    logic       legit;

    function automatic logic [7:0] puf_func(input logic [7:0] c);
        return (c * 8'd37) ^ 8'h5C ^ {c[0], c[7:1]};
    endfunction

    always @(posedge clk) begin
        if (puf_rst) begin
            stub_cnt   <= 0;
            rst_pulses <= rst_pulses + 1;
            if (mode == 3 && (rst_pulses - tab_base) >= 0 && (rst_pulses - tab_base) < 5)
                stub_resp <= tab[rst_pulses - tab_base];
            else
                stub_resp <= puf_func(puf_chall);
        end else if (stub_cnt < 100) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    always_comb begin
        case (mode)
            1: begin
                legit     = (stub_cnt >= 5);
                puf_ready = (stub_cnt < 3) || legit;
            end
            2: begin
                legit     = 1'b0;
                puf_ready = 1'b0;
            end
            default: begin
                legit     = (stub_cnt >= 2);
                puf_ready = legit;
            end
        endcase
        puf_response = legit ? stub_resp : ~stub_resp;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] r, input logic [7:0] u,
                        input logic t, input bit push);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_chall = c;
        tick();
        req_valid = 1'b0;
        req_chall = ~c;
        if (push) sb.push_back('{chall: c, resp: r, unst: u, tmo: t});
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        check("out_valid_wait", 32'(out_valid), 32'(1));
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, ".sb_depth"}, 32'(sb.size()), 32'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".chall"}, 32'(out_chall), 32'(e.chall));
            check({tag, ".resp"}, 32'(out_resp), 32'(e.resp));
            check({tag, ".timeout"}, 32'(out_timeout), 32'(e.tmo));
`ifdef PUF_STABILITY_MASK_EN
            check({tag, ".unstable"}, 32'(out_unstable), 32'(e.unst));
`endif
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic [7:0] c, input logic [7:0] r,
                          input logic [7:0] u, input logic t, output int cyc,
                          output logic [7:0] got);
        send(c, r, u, t, 1'b1);
        wait_out(cyc);
        got = out_resp;
        check_out(tag);
        ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         n;
        int         base;
        bit         bad;
        logic [7:0] got;
        logic [7:0] pass1[256];

        rst       = 1'b1;
        req_valid = 1'b0;
        req_chall = 8'h00;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst.req_ready", 32'(req_ready), 32'(1));
        check("rst.ctrl", 32'({puf_en, puf_rst, out_valid, out_timeout}), 32'(0));
        check("rst.data", 32'({puf_chall, out_chall, out_resp}), 32'(0));
`ifdef PUF_STABILITY_MASK_EN
        check("rst.unstable", 32'(out_unstable), 32'(0));
`endif
        rst = 1'b0;
        tick();

        // 1: constant A5 response, latency 5 cycles per sample with this stub
        mode = 3;
        tab = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        tab_base = rst_pulses;
        send(8'hD4, 8'hA5, 8'h00, 1'b0, 1'b1);
        check("t1.busy", 32'({puf_en, puf_rst, req_ready}), 32'(3'b110));
        check("t1.puf_chall", 32'(puf_chall), 32'(8'hD4));
        wait_out(cyc);
        check("t1.latency", 32'(cyc), 32'(25));
        check("t1.puf_en_off", 32'(puf_en), 32'(0));
        check_out("t1");
        ack();

        // 2: mixed samples vote to A5, every bit disagreed
        tab = '{8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'h5A};
        tab_base = rst_pulses;
        do_req("t2", 8'h3C, 8'hA5, 8'hFF, 1'b0, cyc, got);

        // 3: stale ready carrying inverted data must be skipped
        mode = 1;
        base = rst_pulses;
        do_req("t3", 8'h77, puf_func(8'h77), 8'h00, 1'b0, cyc, got);
        check("t3.rst_pulses", 32'(rst_pulses - base), 32'(5));

        // 4: ready stuck low aborts, then the block recovers
        mode = 2;
        do_req("t4.tmo", 8'h81, 8'h00, 8'hFF, 1'b1, cyc, got);
        mode = 0;
        do_req("t4.next", 8'h82, puf_func(8'h82), 8'h00, 1'b0, cyc, got);

        // 5: back-pressure holds the result and blocks new requests
        send(8'h5E, puf_func(8'h5E), 8'h00, 1'b0, 1'b1);
        wait_out(cyc);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_chall = 8'hEE;
            tick();
            check("t5.hold", 32'({out_valid, req_ready, out_chall, out_resp}),
                  32'({1'b1, 1'b0, 8'h5E, puf_func(8'h5E)}));
        end
        req_valid = 1'b0;
        check_out("t5");
        ack();
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid || puf_en || !req_ready) bad = 1'b1;
            tick();
        end
        check("t5.no_accept", 32'(bad), 32'(0));

        // 6: reset during the third sample aborts with no result
        base = rst_pulses;
        send(8'h99, 8'h00, 8'h00, 1'b0, 1'b0);
        n = 0;
        while ((rst_pulses - base) < 3 && n < 300) begin
            tick();
            n++;
        end
        check("t6.third_sample", 32'(rst_pulses - base), 32'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6.after_rst", 32'({req_ready, puf_en, puf_rst, out_valid}), 32'(4'b1000));
        check("t6.data_clr", 32'({out_chall, out_resp}), 32'(0));
        mode = 3;
        tab = '{8'h0F, 8'h0F, 8'hF0, 8'h0F, 8'h0F};
        tab_base = rst_pulses;
        do_req("t6.fresh", 8'h42, 8'h0F, 8'hFF, 1'b0, cyc, got);

        // Sweep: two passes over every challenge must agree
        mode = 0;
        for (int c = 0; c < 256; c++) begin
            do_req("sweep1", 8'(c), puf_func(8'(c)), 8'h00, 1'b0, cyc, got);
            pass1[c] = got;
        end
        for (int c = 0; c < 256; c++) begin
            do_req("sweep2", 8'(c), puf_func(8'(c)), 8'h00, 1'b0, cyc, got);
            check("sweep.repeat", 32'(got), 32'(pass1[c]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
